// File: rtl/output_serializer_pkg.sv
// Shared types and sizing helpers for the output serializer.
package output_serializer_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    // Width of the bit counter needed to count 0..width-1.
    function automatic int SER_CNT_W(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/output_slot_buffer.sv
// Two-slot ping-pong word store feeding the serializer's shift register.
module output_slot_buffer
    import output_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_input,
    input  logic                  accept,
    input  logic                  load,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  not_empty,
    output logic                  buffer_ready
);

    logic [DATA_WIDTH-1:0] slot [2];
    logic                  wr_sel;
    logic                  rd_sel;
    logic [1:0]            count;
    logic [1:0]            count_next;

    // Occupancy after this edge; a simultaneous accept and load cancel out.
    always_comb begin
        count_next = count;
        unique case ({accept, load})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Slot writes, pointer toggles, occupancy and the registered ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot[0]      <= '0;
            slot[1]      <= '0;
            wr_sel       <= 1'b0;
            rd_sel       <= 1'b0;
            count        <= '0;
            buffer_ready <= 1'b0;
        end else begin
            if (accept) begin
                slot[wr_sel] <= data_input;
                wr_sel       <= ~wr_sel;
            end
            if (load) begin
                rd_sel <= ~rd_sel;
            end
            count        <= count_next;
            buffer_ready <= (count_next < 2'd2);
        end
    end

    assign load_data = slot[rd_sel];
    assign not_empty = (count != 2'd0);

endmodule

// File: rtl/output_serializer.sv
// MSB-first parallel-to-serial transmitter with a two-word input buffer.
module output_serializer
    import output_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_input,
    input  logic                  data_valid,
    output logic                  buffer_ready,
    input  logic                  bit_tick,
    output logic                  serial_out,
    output logic                  serial_valid,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int CNT_W = SER_CNT_W(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    ser_state_t            state;
    ser_state_t            state_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_cnt_next;
    logic                  frame_done_next;
    logic                  accept;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  not_empty;

    assign accept = data_valid && buffer_ready;

    output_slot_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .data_input  (data_input),
        .accept      (accept),
        .load        (load),
        .load_data   (load_data),
        .not_empty   (not_empty),
        .buffer_ready(buffer_ready)
    );

    // Next-state, shifter update and buffer load request.
    always_comb begin
        state_next      = state;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt;
        load            = 1'b0;
        frame_done_next = 1'b0;
        unique case (state)
            SER_IDLE: begin
                if (not_empty) begin
                    load         = 1'b1;
                    shift_next   = load_data;
                    bit_cnt_next = '0;
                    state_next   = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (bit_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        frame_done_next = 1'b1;
                        // Reload on the final tick so consecutive frames abut.
                        if (not_empty) begin
                            load         = 1'b1;
                            shift_next   = load_data;
                            bit_cnt_next = '0;
                        end else begin
                            state_next = SER_IDLE;
                        end
                    end else begin
                        shift_next   = {shift_reg[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_next = SER_IDLE;
        endcase
    end

    // State register and shifter datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SER_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            bit_cnt    <= bit_cnt_next;
            frame_done <= frame_done_next;
        end
    end

    assign serial_valid = (state == SER_SHIFT);
    assign serial_out   = (state == SER_SHIFT) ? shift_reg[DATA_WIDTH-1] : 1'b0;
    assign busy         = (state == SER_SHIFT) || not_empty;

endmodule
